shift_mul_ctrl: RTL and testbench

//  Sequencer that runs a 6-bit unsigned shift-and-add multiply on the ALU's shared

---
 rtl/shift_mul_ctrl.sv | 73 +++++++
 tb/tb_shift_mul_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/shift_mul_ctrl.sv
// shift_mul_ctrl: shift-and-add 6-bit multiply sequencer driving the ALU's shared left shifter
// Optional EARLY_EXIT_EN ends the run once no set multiplier bits remain.
module shift_mul_ctrl #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_b,
  input  logic [WIDTH-1:0] sh_c
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic ovf_q, last, lost;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] wide;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, sh_c};
    // bits of the multiplicand pushed past the top by this shift
    wide = {{WIDTH{1'b0}}, a_q} << idx;
    lost = |wide[2*WIDTH-1:WIDTH];
`ifdef EARLY_EXIT_EN
    last = (idx == CNT_W'(WIDTH - 1)) || ((b_q >> (idx + 1'b1)) == '0);
`else
    last = idx == CNT_W'(WIDTH - 1);
`endif
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_q   <= op_a;
        b_q   <= op_b;
        acc   <= '0;
        ovf_q <= 1'b0;
        idx   <= '0;
      end else if (state == RUN) begin
        idx <= last ? '0 : idx + 1'b1;
        if (b_q[idx]) begin
          acc <= sum[WIDTH-1:0];
          if (sum[WIDTH] || lost) ovf_q <= 1'b1;
        end
      end
    end
  end
  assign ready  = state == IDLE;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign result = acc;
  assign ovf    = ovf_q;
  assign sh_a   = busy ? a_q : '0;
  assign sh_b   = busy ? {{(WIDTH-CNT_W){1'b0}}, idx} : '0;
endmodule

// File: tb/tb_shift_mul_ctrl.sv
// tb_shift_mul_ctrl: directed vector bench for shift_mul_ctrl with a behavioural left shifter
module tb_shift_mul_ctrl;
  logic clk = 1'b0;
  logic rst, start;
  logic [5:0] op_a, op_b, result, sh_a, sh_b, sh_c;
  logic ready, busy, done, ovf;
  int n_pass = 0;
  int n_total = 0;

  shift_mul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .result(result), .ovf(ovf),
    .sh_a(sh_a), .sh_b(sh_b), .sh_c(sh_c)
  );

  assign sh_c = sh_a << sh_b;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] res;
    logic       ovf;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_lat(input logic [5:0] b);
`ifdef EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 6; i++) if (b[i]) m = i;
    return 2 + m;
`else
    return 7;
`endif
  endfunction

  // counts edges after the sampling edge until done is seen at a negedge
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    v[0] = '{6'd5,  6'd7,  6'd35, 1'b0};
    v[1] = '{6'd63, 6'd63, 6'd1,  1'b1};
    v[2] = '{6'd8,  6'd8,  6'd0,  1'b1};
    v[3] = '{6'd42, 6'd0,  6'd0,  1'b0};
    v[4] = '{6'd3,  6'd5,  6'd15, 1'b0};
    v[5] = '{6'd21, 6'd3,  6'd63, 1'b0};
    v[6] = '{6'd32, 6'd2,  6'd0,  1'b1};
    v[7] = '{6'd1,  6'd63, 6'd63, 1'b0};
    v[8] = '{6'd9,  6'd7,  6'd63, 1'b0};
    v[9] = '{6'd11, 6'd6,  6'd2,  1'b1};
    rst = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sh_a", sh_a, 0);
    chk("rst_sh_b", sh_b, 0);

    for (int k = 0; k < 10; k++) begin
      launch(v[k].a, v[k].b);
      chk($sformatf("v%0d_busy", k), busy | done, 1);
      wait_done(n);
      chk($sformatf("v%0d_done", k), done, 1);
      chk($sformatf("v%0d_lat", k), n + 1, exp_lat(v[k].b));
      chk($sformatf("v%0d_result", k), result, v[k].res);
      chk($sformatf("v%0d_ovf", k), ovf, v[k].ovf);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), ready, 1);
      chk($sformatf("v%0d_hold", k), result, v[k].res);
      chk($sformatf("v%0d_pulse", k), done, 0);
    end

    // start held high through the run with changed operands
    launch(6'd3, 6'd5);
    start = 1'b1;
    op_a = 6'd7;
    op_b = 6'd7;
    wait_done(n);
    chk("held_done", done, 1);
    chk("held_first", result, 15);
    @(posedge clk);
    @(negedge clk);
    chk("held_idle", ready, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("held_accept", ready, 0);
    wait_done(n);
    chk("held_second", result, 49);
    chk("held_ovf", ovf, 0);
    @(posedge clk);
    @(negedge clk);

    // reset mid-run
    launch(6'd5, 6'd7);
    chk("mid_sh_b0", sh_b, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_sh_b1", sh_b, 1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_sh_b2", sh_b, 2);
    chk("mid_sh_a", sh_a, 5);
    chk("mid_acc", result, 15);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", ready, 1);
    chk("mrst_done", done, 0);
    chk("mrst_result", result, 0);
    chk("mrst_sh_b", sh_b, 0);
    chk("mrst_sh_a", sh_a, 0);
    chk("mrst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
